ber_checker: RTL and testbench
==============================

// Module: ber_checker
// PURPOSE
//  Receive-side consumer of the tx FIR output: decimates the N_OS-oversampled filter output to one
//  sample per symbol at a selectable phase, slices it to a bit, aligns it to the reference PRBS bit
//  stream by delay search, then counts bit errors and compared bits. Sits after the FIR filter.
// PARAMETERS
//  N_OS      4     oversampling factor (samples per symbol), power of 2
//  NB_I      8     input sample width, signed Q(NB_I,NBF_I)
//  NBF_I     7     fractional bits of input sample (informative; slicer uses the sign bit only)
//  PRBS_LEN  511   reference buffer depth = max delay + 1 = search window length (bits)
//  NB_CNT    64    width of error and bit counters
// PORTS
//  i_clk     in   1               system clock, one filter output sample per cycle
//  i_reset   in   1               asynchronous, active-low reset
//  i_enable  in   1               symbol strobe, 1 cycle every N_OS, same strobe that shifts the FIR
//  i_phase   in   $clog2(N_OS)    decimation phase; sampled on the capture cycle
//  i_sample  in   NB_I            signed FIR output sample
//  i_ref     in   1               reference bit from PRBS; valid when i_enable=1
//  o_lock    out  1               1 = aligned, counters accumulating
//  o_delay   out  $clog2(PRBS_LEN) current alignment delay, in symbols
//  o_err_cnt out  NB_CNT          bit errors since lock
//  o_bit_cnt out  NB_CNT          bits compared since lock
// BEHAVIOUR
//  Reset (i_reset=0, async): phase counter 0, wr_ptr 0, ref buffer all 0, state SEARCH, o_lock 0,
//   o_delay 0, o_err_cnt 0, o_bit_cnt 0, window counters 0. Effect is immediate, including mid-search.
//  Phase counter: loads 0 on i_enable=1, else increments, wrapping N_OS-1 -> 0 (free-runs if no strobe).
//  Capture: when phase counter == i_phase, rx_bit = i_sample[NB_I-1] (1 = negative symbol);
//   exactly one decision per symbol. Sample 0 is 0 -> rx_bit 0.
//  Ref buffer: on i_enable, buf[wr_ptr] <= i_ref; wr_ptr wraps PRBS_LEN-1 -> 0.
//   Compared bit = buf[(wr_ptr - 1 - o_delay) mod PRBS_LEN], wr_ptr taken before that cycle's write
//   (capture coincident with i_enable, i.e. i_phase=0, sees the pre-write pointer).
//  Compare result registered: err/count updates appear 1 cycle after capture cycle.
//  FSM SEARCH: win_bits++, win_errs += (rx_bit != ref) per decision. When win_bits reaches PRBS_LEN:
//   win_errs==0 -> LOCK (o_lock=1 next cycle, o_err_cnt/o_bit_cnt start from 0);
//   else o_delay++ (PRBS_LEN-1 -> 0 wrap), window counters cleared, stay SEARCH.
//  FSM LOCK: o_bit_cnt++ per decision, o_err_cnt++ on mismatch; o_delay frozen.
//   Both counters saturate at all-ones; o_err_cnt never exceeds o_bit_cnt.
//  i_phase change in LOCK: no reset of state; new phase applies from next symbol.
// CONFIGURATION
//  BER_RELOCK_EN defined: in LOCK, window counters keep running over PRBS_LEN-bit windows; a window
//   with win_errs > PRBS_LEN/2 (integer division) -> SEARCH, o_lock=0, o_delay++,
//   o_err_cnt/o_bit_cnt held (not cleared) until the next lock, then cleared.
//  BER_RELOCK_EN undefined: LOCK is sticky until reset; no window counting in LOCK.
// TESTING
//  1 Reset: drive i_reset=0 mid-stream -> all outputs 0, o_lock=0, state SEARCH within same cycle.
//  2 PRBS9 through FIR, i_phase=2, true latency 3 symbols -> o_delay=3, o_lock=1 after 4*511 decisions,
//    then o_err_cnt=0, o_bit_cnt=1000 after 1000 further symbols.
//  3 Locked, invert rx sign on exactly 7 symbols of 2000 -> o_err_cnt=7, o_bit_cnt=2000.
//  4 True delay 510 -> o_delay walks 0..510, locks at 510; inject 1 error per window at delay 510 ->
//    wrap to o_delay=0 and continue search.
//  5 Counter saturation: NB_CNT=4, 20 locked symbols -> o_bit_cnt holds 15.
//  6 BER_RELOCK_EN: locked, invert all symbols for 511 -> o_lock=0, counters held, relock after realign.

Source files
------------

// File: rtl/ber_checker.sv
// ber_checker
//   Receive-side BER checker placed after the tx FIR filter. Decimates the
//   N_OS-oversampled filter output to one decision per symbol at a selectable
//   phase, slices it on the sign bit, searches for the delay that aligns the
//   decisions with the reference PRBS stream, then counts bit errors and
//   compared bits once aligned.
//
//   Ports
//     i_clk      system clock, one filter sample per cycle
//     i_reset    asynchronous, active-low reset
//     i_enable   symbol strobe, one cycle every N_OS
//     i_phase    decimation phase, sampled on the capture cycle
//     i_sample   signed filter output sample
//     i_ref      reference PRBS bit, valid with i_enable
//     o_lock     1 = aligned, counters accumulating
//     o_delay    current alignment delay in symbols
//     o_err_cnt  bit errors since lock (saturating)
//     o_bit_cnt  bits compared since lock (saturating)
//
//   Configuration macro
//     BER_RELOCK_EN  when defined, a locked checker keeps scoring PRBS_LEN-bit
//                    windows and drops back to search on a window with more
//                    than PRBS_LEN/2 errors. Undefined: lock is sticky.
module ber_checker #(
   parameter int N_OS     = 4,
   parameter int NB_I     = 8,
   parameter int NBF_I    = 7,
   parameter int PRBS_LEN = 511,
   parameter int NB_CNT   = 64
) (
   input  logic                        i_clk,
   input  logic                        i_reset,
   input  logic                        i_enable,
   input  logic [$clog2(N_OS)-1:0]     i_phase,
   input  logic [NB_I-1:0]             i_sample,
   input  logic                        i_ref,
   output logic                        o_lock,
   output logic [$clog2(PRBS_LEN)-1:0] o_delay,
   output logic [NB_CNT-1:0]           o_err_cnt,
   output logic [NB_CNT-1:0]           o_bit_cnt
);

   localparam int PW = $clog2(N_OS);
   localparam int DW = $clog2(PRBS_LEN);
   localparam int WW = $clog2(PRBS_LEN + 1);

   localparam logic ST_SEARCH = 1'b0;
   localparam logic ST_LOCK   = 1'b1;

   // Only the sign bit is sliced; the fraction format is informative.
   localparam logic NBF_ODD = 1'((NBF_I % 2) != 0);
   logic unused_sample_bits;
   assign unused_sample_bits = ^{i_sample[NB_I-2:0], NBF_ODD};

   logic [PW-1:0]       phase_q, phase_d;
   logic [DW-1:0]       wr_ptr_q, wr_ptr_d;
   logic [PRBS_LEN-1:0] ref_buf_q, ref_buf_d;
   logic                state_q, state_d;
   logic [DW-1:0]       delay_q, delay_d;
   logic [WW-1:0]       win_bits_q, win_bits_d;
   logic [WW-1:0]       win_errs_q, win_errs_d;
   logic [NB_CNT-1:0]   err_cnt_q, err_cnt_d;
   logic [NB_CNT-1:0]   bit_cnt_q, bit_cnt_d;

   logic [PW-1:0] phase_now;
   logic          capture;
   logic          rx_bit;
   logic [DW:0]   rd_sum;
   logic [DW:0]   rd_wrap;
   logic [DW-1:0] rd_idx;
   logic          ref_bit;
   logic          mism;
   logic [WW-1:0] win_bits_inc;
   logic [WW-1:0] win_errs_inc;
   logic          win_full;
   logic [DW-1:0] delay_inc;

   always_comb begin
      // The phase seen in a strobe cycle is already 0, so phase 0 captures
      // coincident with i_enable and sees the pre-write buffer pointer.
      phase_now = i_enable ? '0 : phase_q + PW'(1);
      phase_d   = phase_now;
      capture   = (phase_now == i_phase);
      rx_bit    = i_sample[NB_I-1];

      wr_ptr_d  = wr_ptr_q;
      ref_buf_d = ref_buf_q;
      if (i_enable) begin
         ref_buf_d[wr_ptr_q] = i_ref;
         wr_ptr_d = (wr_ptr_q == DW'(PRBS_LEN - 1)) ? '0 : wr_ptr_q + DW'(1);
      end

      // (wr_ptr - 1 - delay) mod PRBS_LEN without a divider: bias by
      // PRBS_LEN-1 so the sum stays non-negative, then fold once.
      rd_sum  = {1'b0, wr_ptr_q} + (DW+1)'(PRBS_LEN - 1) - {1'b0, delay_q};
      rd_wrap = rd_sum - (DW+1)'(PRBS_LEN);
      rd_idx  = (rd_sum >= (DW+1)'(PRBS_LEN)) ? rd_wrap[DW-1:0] : rd_sum[DW-1:0];
      ref_bit = ref_buf_q[rd_idx];
      mism    = rx_bit ^ ref_bit;

      win_bits_inc = win_bits_q + WW'(1);
      win_errs_inc = win_errs_q + {{(WW-1){1'b0}}, mism};
      win_full     = (win_bits_inc == WW'(PRBS_LEN));
      delay_inc    = (delay_q == DW'(PRBS_LEN - 1)) ? '0 : delay_q + DW'(1);

      state_d    = state_q;
      delay_d    = delay_q;
      win_bits_d = win_bits_q;
      win_errs_d = win_errs_q;
      err_cnt_d  = err_cnt_q;
      bit_cnt_d  = bit_cnt_q;

      if (capture) begin
         if (state_q == ST_SEARCH) begin
            win_bits_d = win_bits_inc;
            win_errs_d = win_errs_inc;
            if (win_full) begin
               win_bits_d = '0;
               win_errs_d = '0;
               if (win_errs_inc == '0) begin
                  state_d   = ST_LOCK;
                  err_cnt_d = '0;
                  bit_cnt_d = '0;
               end else begin
                  delay_d = delay_inc;
               end
            end
         end else begin
            // err only advances while below all-ones, so it can never pass bit.
            if (bit_cnt_q != '1) bit_cnt_d = bit_cnt_q + NB_CNT'(1);
            if (mism && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + NB_CNT'(1);
`ifdef BER_RELOCK_EN
            win_bits_d = win_bits_inc;
            win_errs_d = win_errs_inc;
            if (win_full) begin
               win_bits_d = '0;
               win_errs_d = '0;
               if (win_errs_inc > WW'(PRBS_LEN / 2)) begin
                  state_d = ST_SEARCH;
                  delay_d = delay_inc;
               end
            end
`endif
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         phase_q    <= '0;
         wr_ptr_q   <= '0;
         ref_buf_q  <= '0;
         state_q    <= ST_SEARCH;
         delay_q    <= '0;
         win_bits_q <= '0;
         win_errs_q <= '0;
         err_cnt_q  <= '0;
         bit_cnt_q  <= '0;
      end else begin
         phase_q    <= phase_d;
         wr_ptr_q   <= wr_ptr_d;
         ref_buf_q  <= ref_buf_d;
         state_q    <= state_d;
         delay_q    <= delay_d;
         win_bits_q <= win_bits_d;
         win_errs_q <= win_errs_d;
         err_cnt_q  <= err_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
      end
   end

   assign o_lock    = (state_q == ST_LOCK);
   assign o_delay   = delay_q;
   assign o_err_cnt = err_cnt_q;
   assign o_bit_cnt = bit_cnt_q;

endmodule

// File: tb/tb_ber_checker.sv
// tb_ber_checker
//   Bench for ber_checker with a short PRBS5 reference (PRBS_LEN = 31) and
//   8-bit counters. A symbol-level reference model pushes expected outputs to
//   a scoreboard as each symbol is driven; entries are popped and compared
//   once the symbol has been clocked through. Honours BER_RELOCK_EN.
module tb_ber_checker;

   localparam int N_OS   = 4;
   localparam int NB_I   = 8;
   localparam int LEN    = 31;
   localparam int NB_CNT = 8;
   localparam int DW     = $clog2(LEN);
   localparam int CMAX   = (1 << NB_CNT) - 1;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              en;
   logic [1:0]        phase;
   logic [NB_I-1:0]   sample;
   logic              ref_bit;
   logic              lock;
   logic [DW-1:0]     delay;
   logic [NB_CNT-1:0] err_cnt;
   logic [NB_CNT-1:0] bit_cnt;

   always #5 clk = ~clk;

   ber_checker #(
      .N_OS(N_OS), .NB_I(NB_I), .NBF_I(7), .PRBS_LEN(LEN), .NB_CNT(NB_CNT)
   ) u_dut (
      .i_clk(clk), .i_reset(rst_n), .i_enable(en), .i_phase(phase),
      .i_sample(sample), .i_ref(ref_bit), .o_lock(lock), .o_delay(delay),
      .o_err_cnt(err_cnt), .o_bit_cnt(bit_cnt)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
   endtask

   typedef struct {
      string tag;
      int    lock;
      int    delay;
      int    ec;
      int    bc;
   } exp_t;

   exp_t sb[$];
   bit   prbs[LEN];
   bit   refs[$];
   int   cur_phase;
   int   m_lock, m_delay, m_wb, m_we, m_ec, m_bc;

   function automatic logic [7:0] make_sample(input bit neg);
      if (neg) return 8'(255 - $urandom_range(0, 127));
      return 8'($urandom_range(0, 127));
   endfunction

   task automatic model_reset();
      m_lock = 0; m_delay = 0; m_wb = 0; m_we = 0; m_ec = 0; m_bc = 0;
      refs.delete();
   endtask

   // One decision of the current symbol (its ref already appended to refs).
   task automatic model_step(input bit rx);
      int k, j;
      bit cmp, err;
      k   = refs.size() - 1;
      j   = (cur_phase == 0) ? k - 1 - m_delay : k - m_delay;
      cmp = (j >= 0) ? refs[j] : 1'b0;
      err = (rx != cmp);
      if (m_lock == 0) begin
         m_wb++;
         m_we += int'(err);
         if (m_wb == LEN) begin
            if (m_we == 0) begin
               m_lock = 1; m_ec = 0; m_bc = 0;
            end else begin
               m_delay = (m_delay + 1) % LEN;
            end
            m_wb = 0; m_we = 0;
         end
      end else begin
         if (m_bc < CMAX) m_bc++;
         if (err && m_ec < CMAX) m_ec++;
`ifdef BER_RELOCK_EN
         m_wb++;
         m_we += int'(err);
         if (m_wb == LEN) begin
            if (m_we > LEN / 2) begin
               m_lock = 0;
               m_delay = (m_delay + 1) % LEN;
            end
            m_wb = 0; m_we = 0;
         end
`endif
      end
   endtask

   // Drives one symbol whose decision carries prbs delayed by lat symbols
   // (optionally inverted). Only the selected phase carries the true sign.
   task automatic run_symbol(input int lat, input bit inv, input string tag);
      int   k;
      bit   rb, want;
      exp_t e;
      k    = refs.size();
      rb   = prbs[k % LEN];
      refs.push_back(rb);
      want = prbs[(k + 10 * LEN - lat) % LEN] ^ inv;
      model_step(want);
      if (tag != "") sb.push_back('{tag, m_lock, m_delay, m_ec, m_bc});
      for (int c = 0; c < N_OS; c++) begin
         en      = (c == 0);
         ref_bit = rb;
         phase   = 2'(cur_phase);
         sample  = make_sample((c == cur_phase) ? want : !want);
         @(posedge clk);
         #1;
      end
      en = 1'b0;
      if (tag != "") begin
         e = sb.pop_front();
         check({e.tag, "_lock"},  64'(lock),    64'(e.lock));
         check({e.tag, "_delay"}, 64'(delay),   64'(e.delay));
         check({e.tag, "_err"},   64'(err_cnt), 64'(e.ec));
         check({e.tag, "_bits"},  64'(bit_cnt), 64'(e.bc));
      end
   endtask

   // Asserts reset between clock edges and checks the outputs clear at once.
   task automatic do_reset(input string tag);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      en    = 1'b0;
      #1;
      check({tag, "_lock"},  64'(lock),    64'(0));
      check({tag, "_delay"}, 64'(delay),   64'(0));
      check({tag, "_err"},   64'(err_cnt), 64'(0));
      check({tag, "_bits"},  64'(bit_cnt), 64'(0));
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [4:0] s;
      rst_n = 1'b1; en = 1'b0; phase = 2'd2; sample = '0; ref_bit = 1'b0;
      s = 5'h1f;
      for (int i = 0; i < LEN; i++) begin
         prbs[i] = s[4];
         s = {s[3:0], s[4] ^ s[2]};
      end
      model_reset();
      cur_phase = 2;
      do_reset("rst0");

      // Search with true latency 3 at phase 2: locks on decision 4*31-1.
      for (int i = 0; i < 124; i++)
         run_symbol(3, 1'b0, (i == 122) ? "pre_lock" : (i == 123) ? "lock" : "");
      check("lock_d3", 64'(lock), 64'(1));
      check("delay_d3", 64'(delay), 64'(3));

      for (int i = 0; i < 100; i++) run_symbol(3, 1'b0, (i == 99) ? "clean" : "");
      check("bits_100", 64'(bit_cnt), 64'(100));
      check("errs_0", 64'(err_cnt), 64'(0));

      for (int i = 0; i < 100; i++)
         run_symbol(3, i inside {3, 17, 30, 44, 61, 80, 99}, (i == 99) ? "inj7" : "");
      check("errs_7", 64'(err_cnt), 64'(7));
      check("bits_200", 64'(bit_cnt), 64'(200));

      for (int i = 0; i < 100; i++) run_symbol(3, 1'b0, (i == 99) ? "sat" : "");
      check("bits_sat", 64'(bit_cnt), 64'(CMAX));

      // Phase changes while locked take effect on the next symbol.
      cur_phase = 1;
      for (int i = 0; i < 10; i++) run_symbol(3, 1'b0, (i == 9) ? "ph1" : "");
      cur_phase = 3;
      for (int i = 0; i < 10; i++) run_symbol(3, 1'b0, (i == 9) ? "ph3" : "");
      check("errs_ph", 64'(err_cnt), 64'(7));

      for (int i = 0; i < 62; i++) run_symbol(3, 1'b1, (i == 61) ? "inv" : "");
`ifdef BER_RELOCK_EN
      check("relock_drop", 64'(lock), 64'(0));
      check("relock_bits_held", 64'(bit_cnt), 64'(CMAX));
      for (int i = 0; i < 1100; i++) run_symbol(3, 1'b0, (i == 1099) ? "relock" : "");
      check("relock_lock", 64'(lock), 64'(1));
      check("relock_delay", 64'(delay), 64'(3));
`else
      check("sticky_lock", 64'(lock), 64'(1));
      check("sticky_errs", 64'(err_cnt), 64'(69));
`endif

      // Maximum delay: walk 0..30, with a reset in the middle of the search.
      cur_phase = 2;
      do_reset("rst_lock");
      for (int i = 0; i < 500; i++) run_symbol(30, 1'b0, (i == 499) ? "walk_mid" : "");
      do_reset("rst_search");
      for (int i = 0; i < 961; i++)
         run_symbol(30, 1'b0, (i == 959) ? "pre_lock30" : (i == 960) ? "lock30" : "");
      check("delay_30", 64'(delay), 64'(30));
      check("lock_30", 64'(lock), 64'(1));

      // One error per window at the true delay forces a wrap back to 0.
      do_reset("rst_wrap");
      for (int i = 0; i < 961; i++) run_symbol(30, (i % LEN) == 0, (i == 960) ? "wrap" : "");
      check("wrap_delay", 64'(delay), 64'(0));
      check("wrap_lock", 64'(lock), 64'(0));

      // Phase 0 sees the pre-write pointer, so latency 3 aligns at delay 2.
      cur_phase = 0;
      do_reset("rst_ph0");
      for (int i = 0; i < 93; i++)
         run_symbol(3, 1'b0, (i == 91) ? "ph0_pre" : (i == 92) ? "ph0_lock" : "");
      check("ph0_delay", 64'(delay), 64'(2));
      check("ph0_lock_const", 64'(lock), 64'(1));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
